// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the writeback register-file write port.
//   WB_AW / WB_DW : default register address / data widths
//   rf_wr_t       : one register-file write (enable, address, data)
//   grant_t       : which source owns the write port in a given cycle
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
  } rf_wr_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_PIPE,
    GNT_FIFO,
    GNT_BYP
  } grant_t;

endpackage

// File: rtl/wb_wrport_arb_if.sv
// -----------------------------------------------------------------------------
// wb_wrport_arb_if
// Bus bundle for the writeback write-port arbiter.
//   i_wb_*   : pipeline WB write request (enable, dest reg, result)
//   i_mdu_*  : MDU result (valid, dest reg, result) with o_mdu_ready back
//   o_rf_*   : register-file write port
//   o_stall_req, o_fifo_empty, o_fifo_count : status to the hazard unit
// Modports: slave = arbiter side, master = pipeline/MDU/regfile side.
// -----------------------------------------------------------------------------
interface wb_wrport_arb_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  logic                     i_wb_we;
  logic [AW-1:0]            i_wb_waddr;
  logic [DW-1:0]            i_wb_wdata;
  logic                     i_mdu_valid;
  logic                     o_mdu_ready;
  logic [AW-1:0]            i_mdu_waddr;
  logic [DW-1:0]            i_mdu_wdata;
  logic                     o_rf_we;
  logic [AW-1:0]            o_rf_waddr;
  logic [DW-1:0]            o_rf_wdata;
  logic                     o_stall_req;
  logic                     o_fifo_empty;
  logic [$clog2(DEPTH):0]   o_fifo_count;

  modport slave (
    input  i_wb_we, i_wb_waddr, i_wb_wdata,
    input  i_mdu_valid, i_mdu_waddr, i_mdu_wdata,
    output o_mdu_ready,
    output o_rf_we, o_rf_waddr, o_rf_wdata,
    output o_stall_req, o_fifo_empty, o_fifo_count
  );

  modport master (
    output i_wb_we, i_wb_waddr, i_wb_wdata,
    output i_mdu_valid, i_mdu_waddr, i_mdu_wdata,
    input  o_mdu_ready,
    input  o_rf_we, o_rf_waddr, o_rf_wdata,
    input  o_stall_req, o_fifo_empty, o_fifo_count
  );
endinterface

// File: rtl/wb_sync_fifo.sv
// -----------------------------------------------------------------------------
// wb_sync_fifo
// Synchronous FIFO buffering MDU results until they win the write port.
//   i_clk, i_rst : clock, asynchronous active-high reset (pointers/count only)
//   i_push, i_wdata : write an entry (ignored when full)
//   i_pop          : consume the head (ignored when empty)
//   o_rdata        : current head entry (show-ahead)
//   o_count, o_empty, o_full : registered occupancy
// Pointers wrap modulo DEPTH; the count tells full from empty.
// -----------------------------------------------------------------------------
module wb_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_wrport_arb.sv
// -----------------------------------------------------------------------------
// wb_wrport_arb
// Shares the single register-file write port between the in-order pipeline
// WB result and buffered MDU results. The pipeline has priority; a starvation
// counter raises a one-cycle WB stall so a waiting MDU result always retires.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : WB request, MDU result/ready, RF write port, status
// Optional feature macro WB_WRPORT_BYPASS_EN: when defined, an MDU result is
// written straight through in the same cycle if the FIFO is empty, the
// pipeline is idle and no stall is active (it is then not pushed).
// -----------------------------------------------------------------------------
module wb_wrport_arb
  import wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int AW       = WB_AW,
  parameter int DW       = WB_DW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  wb_wrport_arb_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAXW = WW'(MAX_WAIT);

  grant_t          w_gnt;
  logic [AW+DW-1:0] w_head;
  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_wdata;
  logic [WW-1:0]   w_wait_nxt;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_stall_req;

  wb_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata ({bus.i_mdu_waddr, bus.i_mdu_wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Grant priority: forced slot, pipeline, FIFO head, bypass, idle.
  always_comb begin
    w_gnt = GNT_IDLE;
    if (r_stall_req && !w_empty)
      w_gnt = GNT_FIFO;
    else if (bus.i_wb_we)
      w_gnt = GNT_PIPE;
    else if (!w_empty)
      w_gnt = GNT_FIFO;
`ifdef WB_WRPORT_BYPASS_EN
    else if (bus.i_mdu_valid)
      w_gnt = GNT_BYP;
`endif
  end

  always_comb begin
    w_waddr = '0;
    w_wdata = '0;
    case (w_gnt)
      GNT_PIPE: begin
        w_waddr = bus.i_wb_waddr;
        w_wdata = bus.i_wb_wdata;
      end
      GNT_FIFO: {w_waddr, w_wdata} = w_head;
      GNT_BYP: begin
        w_waddr = bus.i_mdu_waddr;
        w_wdata = bus.i_mdu_wdata;
      end
      default: ;
    endcase
  end

  // Ready looks only at the registered count, so a full FIFO refuses even
  // when it pops in the same cycle.
  assign w_pop  = (w_gnt == GNT_FIFO);
  assign w_push = bus.i_mdu_valid && !w_full && (w_gnt != GNT_BYP);

  // The waiting head counts up until popped; it saturates as a safety net.
  assign w_wait_nxt = (w_empty || w_pop) ? '0 :
                      (r_wait_cnt == MAXW) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt  <= '0;
      r_stall_req <= 1'b0;
    end else begin
      r_wait_cnt  <= w_wait_nxt;
      r_stall_req <= (w_wait_nxt == MAXW) && (r_wait_cnt != MAXW);
    end
  end

  // Register 0 is hardwired: the source is consumed but nothing is written.
  assign bus.o_rf_we      = (w_gnt != GNT_IDLE) && (w_waddr != '0);
  assign bus.o_rf_waddr   = w_waddr;
  assign bus.o_rf_wdata   = w_wdata;
  assign bus.o_mdu_ready  = !w_full;
  assign bus.o_stall_req  = r_stall_req;
  assign bus.o_fifo_empty = w_empty;
  assign bus.o_fifo_count = w_count;

endmodule
